// File: rtl/i2s_dac_stream_tx.sv
// I2S DAC transmitter: buffers {left,right} frames in a FIFO and serialises them MSB-first
// against the codec-mastered bclk/daclrc, counting frames sent while the FIFO was empty.
module i2s_dac_stream_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MONO       = 0,
  parameter int UNDER_HOLD = 0
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        bclk_export,
  input  logic                        daclrc_export,
  output logic                        dacdat_export,
  input  logic [2*DATA_W-1:0]         snk_data,
  input  logic                        snk_valid,
  output logic                        snk_ready,
  input  logic                        tx_en,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic [15:0]                 under_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {
    ST_WAIT_LEFT,
    ST_LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          bclk_sync_q, bclk_sync_d;
  logic [1:0]          lrc_sync_q, lrc_sync_d;
  logic                bclk_last_q, bclk_last_d;
  logic                lrc_last_q, lrc_last_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   right_q, right_d;
  logic [2*DATA_W-1:0] last_q, last_d;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                dacdat_q, dacdat_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         under_cnt_q, under_cnt_d;
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic                bclk_s, lrc_s, rise_ev, fall_ev;
  logic                left_b, right_b;
  logic [AW:0]         level;
  logic                full, push, pop, under_ev;
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0]   head_l, head_r;

  assign bclk_s  = bclk_sync_q[1];
  assign lrc_s   = lrc_sync_q[1];
  assign rise_ev = bclk_s & ~bclk_last_q;
  assign fall_ev = ~bclk_s & bclk_last_q;
  assign left_b  = rise_ev && (lrc_s != lrc_last_q) && !lrc_s;
  assign right_b = rise_ev && (lrc_s != lrc_last_q) && lrc_s;

  assign level  = wr_ptr_q - rd_ptr_q;
  assign full   = (level == (AW+1)'(FIFO_DEPTH));
  assign push   = snk_valid && !full;
  assign head   = mem_q[rd_ptr_q[AW-1:0]];
  assign head_r = head[DATA_W-1:0];
  assign head_l = (MONO != 0) ? head[DATA_W-1:0] : head[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d     = state_q;
    bclk_sync_d = {bclk_sync_q[0], bclk_export};
    lrc_sync_d  = {lrc_sync_q[0], daclrc_export};
    bclk_last_d = bclk_s;
    lrc_last_d  = lrc_last_q;
    shreg_d     = shreg_q;
    right_d     = right_q;
    last_d      = last_q;
    bitcnt_d    = bitcnt_q;
    dacdat_d    = dacdat_q;
    underrun_d  = underrun_q;
    under_cnt_d = under_cnt_q;
    pop         = 1'b0;
    under_ev    = 1'b0;

    if (rise_ev) begin
      lrc_last_d = lrc_s;
    end

    // A boundary reload always wins over any bits still pending in shreg.
    if (left_b) begin
      state_d  = ST_LOCKED;
      bitcnt_d = CW'(DATA_W);
      shreg_d  = '0;
      right_d  = '0;
      if (tx_en) begin
        if (level != '0) begin
          pop     = 1'b1;
          shreg_d = head_l;
          right_d = head_r;
          last_d  = {head_l, head_r};
        end else begin
          under_ev = 1'b1;
          if (UNDER_HOLD != 0) begin
            shreg_d = last_q[2*DATA_W-1:DATA_W];
            right_d = last_q[DATA_W-1:0];
          end
        end
      end
    end else if (right_b && (state_q == ST_LOCKED)) begin
      shreg_d  = right_q;
      bitcnt_d = CW'(DATA_W);
    end else if (fall_ev) begin
      if (bitcnt_q != '0) begin
        dacdat_d = shreg_q[DATA_W-1];
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q - CW'(1);
      end else begin
        dacdat_d = 1'b0;
      end
    end

    if (under_ev) begin
      underrun_d = 1'b1;
      if (underrun_clr) begin
        under_cnt_d = 16'd1;
      end else if (under_cnt_q != 16'hFFFF) begin
        under_cnt_d = under_cnt_q + 16'd1;
      end
    end else if (underrun_clr) begin
      underrun_d  = 1'b0;
      under_cnt_d = '0;
    end

    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_WAIT_LEFT;
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      bclk_last_q <= 1'b0;
      lrc_last_q  <= 1'b0;
      shreg_q     <= '0;
      right_q     <= '0;
      last_q      <= '0;
      bitcnt_q    <= '0;
      dacdat_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underrun_q  <= 1'b0;
      under_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lrc_sync_q  <= lrc_sync_d;
      bclk_last_q <= bclk_last_d;
      lrc_last_q  <= lrc_last_d;
      shreg_q     <= shreg_d;
      right_q     <= right_d;
      last_q      <= last_d;
      bitcnt_q    <= bitcnt_d;
      dacdat_q    <= dacdat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      underrun_q  <= underrun_d;
      under_cnt_q <= under_cnt_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= snk_data;
    end
  end

  assign dacdat_export = dacdat_q;
  assign snk_ready     = !full;
  assign fifo_level    = level;
  assign underrun      = underrun_q;
  assign under_cnt     = under_cnt_q;

endmodule

// File: tb/tb_i2s_dac_stream_tx.sv
// Bench for i2s_dac_stream_tx: acts as the codec (bclk/daclrc master, 32-bit slots) for two
// differently configured instances and decodes their serial output against a frame-level model.
module tb_i2s_dac_stream_tx;

  logic        clk = 1'b0;
  logic        rst, bclk, lrc, tx_en, clr;
  logic [31:0] a_data;
  logic        a_valid, a_ready, a_dac, a_under;
  logic [3:0]  a_level;
  logic [15:0] a_cnt;
  logic [47:0] b_data;
  logic        b_valid, b_ready, b_dac, b_under;
  logic [2:0]  b_level;
  logic [15:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one entry per instance (0 = a, 1 = b).
  int          dw    [2] = '{16, 24};
  int          depth [2] = '{8, 4};
  bit          mono  [2] = '{1'b0, 1'b1};
  bit          hold  [2] = '{1'b0, 1'b1};
  logic [47:0] mfifo [2][16];
  int          mhead [2];
  int          mcnt  [2];
  bit          m_under [2];
  int          m_ucnt  [2];
  logic [31:0] last_l [2];
  logic [31:0] last_r [2];
  bit          lrc_last_m;

  always #5 clk = ~clk;

  i2s_dac_stream_tx #(.DATA_W(16), .FIFO_DEPTH(8), .MONO(0), .UNDER_HOLD(0)) dut_a (
    .clk_clk(clk), .reset_reset(rst), .bclk_export(bclk), .daclrc_export(lrc),
    .dacdat_export(a_dac), .snk_data(a_data), .snk_valid(a_valid), .snk_ready(a_ready),
    .tx_en(tx_en), .fifo_level(a_level), .underrun(a_under), .underrun_clr(clr),
    .under_cnt(a_cnt)
  );

  i2s_dac_stream_tx #(.DATA_W(24), .FIFO_DEPTH(4), .MONO(1), .UNDER_HOLD(1)) dut_b (
    .clk_clk(clk), .reset_reset(rst), .bclk_export(bclk), .daclrc_export(lrc),
    .dacdat_export(b_dac), .snk_data(b_data), .snk_valid(b_valid), .snk_ready(b_ready),
    .tx_en(tx_en), .fifo_level(b_level), .underrun(b_under), .underrun_clr(clr),
    .under_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mhead[d] = 0; mcnt[d] = 0; m_under[d] = 1'b0; m_ucnt[d] = 0;
      last_l[d] = '0; last_r[d] = '0;
    end
    lrc_last_m = 1'b0;
  endtask

  // Frame-level rule applied at the start of each LRC frame.
  task automatic model_frame(input int d, input bit bnd, output logic [31:0] l,
                             output logic [31:0] r);
    logic [47:0] f;
    logic [31:0] m;
    m = 32'hFFFF_FFFF >> (32 - dw[d]);
    l = '0;
    r = '0;
    if (bnd && tx_en) begin
      if (mcnt[d] > 0) begin
        f = mfifo[d][mhead[d]];
        mhead[d] = (mhead[d] + 1) % 16;
        mcnt[d]--;
        r = f[31:0] & m;
        l = mono[d] ? r : 32'((f >> dw[d]) & 48'(m));
        last_l[d] = l;
        last_r[d] = r;
      end else begin
        m_under[d] = 1'b1;
        if (m_ucnt[d] < 65535) m_ucnt[d]++;
        if (hold[d]) begin
          l = last_l[d];
          r = last_r[d];
        end
      end
    end
  endtask

  task automatic check_status();
    check("a_level", a_level, mcnt[0]);
    check("a_ready", a_ready, mcnt[0] < depth[0]);
    check("a_underrun", a_under, m_under[0]);
    check("a_under_cnt", a_cnt, m_ucnt[0]);
    check("b_level", b_level, mcnt[1]);
    check("b_ready", b_ready, mcnt[1] < depth[1]);
    check("b_underrun", b_under, m_under[1]);
    check("b_under_cnt", b_cnt, m_ucnt[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1; bclk = 1'b0; a_valid = 1'b0; b_valid = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_status();
    check("a_dac_reset", a_dac, 1'b0);
    check("b_dac_reset", b_dac, 1'b0);
  endtask

  task automatic push_frame(input int d, input logic [47:0] f);
    if (d == 0) begin
      a_data = f[31:0]; a_valid = 1'b1;
    end else begin
      b_data = f; b_valid = 1'b1;
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    mfifo[d][(mhead[d] + mcnt[d]) % 16] = f;
    mcnt[d]++;
  endtask

  task automatic push_random(input int d, input int k);
    for (int i = 0; i < k; i++) begin
      push_frame(d, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_under[d] = 1'b0;
      m_ucnt[d] = 0;
    end
    @(negedge clk);
    check_status();
  endtask

  // Runs n codec frames (64 bclk each) plus one trailing bclk to collect the last delayed bit.
  task automatic run_frames(input int n, input bit rand_en);
    logic [31:0] exp_s [2][64];
    logic [31:0] acc [2];
    logic [31:0] l, r;
    int idx;
    acc[0] = '0;
    acc[1] = '0;
    for (int p = 0; p <= 64 * n; p++) begin
      if (p < 64 * n) begin
        if (p % 64 == 0) begin
          for (int d = 0; d < 2; d++) begin
            model_frame(d, (p > 0) || lrc_last_m, l, r);
            exp_s[d][2 * (p / 64)]     = l;
            exp_s[d][2 * (p / 64) + 1] = r;
          end
        end
        lrc = ((p % 64) >= 32);
        if (rand_en && (p % 64 == 16)) tx_en = ($urandom_range(0, 3) != 0);
      end
      bclk = 1'b0;
      repeat (4) @(negedge clk);
      if (p >= 1) begin
        idx = p - 1;
        acc[0] = {acc[0][30:0], a_dac};
        acc[1] = {acc[1][30:0], b_dac};
        if (idx % 32 == 31) begin
          for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_slot%0d", (d == 0) ? "a" : "b", idx / 32), acc[d],
                  exp_s[d][idx / 32] << (32 - dw[d]));
          end
        end
      end
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    bclk = 1'b0;
    lrc_last_m = 1'b1;
    repeat (8) @(negedge clk);
    check_status();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bclk = 1'b0; lrc = 1'b0; tx_en = 1'b0; clr = 1'b0;
    a_data = '0; a_valid = 1'b0; b_data = '0; b_valid = 1'b0;
    @(negedge clk);
    do_reset();

    // Known frame on each instance; mono instance must ignore its upper half.
    tx_en = 1'b1;
    push_frame(0, 48'h0000_A55A_0F0F);
    push_frame(1, 48'hABCDEF_008001);
    check_status();
    run_frames(2, 1'b0);

    // Starvation: zeros on a, held frame repeated on b; both count every frame.
    run_frames(3, 1'b0);
    clr_pulse();

    // Randomised traffic, tx_en toggling between frames.
    for (int it = 0; it < 6; it++) begin
      for (int d = 0; d < 2; d++) begin
        push_random(d, $urandom_range(0, depth[d] - mcnt[d]));
      end
      tx_en = ($urandom_range(0, 3) != 0);
      check_status();
      run_frames($urandom_range(1, 3), 1'b1);
      if ($urandom_range(0, 2) == 0) clr_pulse();
    end

    // Fill both FIFOs with no bclk, then drain in order.
    do_reset();
    tx_en = 1'b1;
    push_random(0, depth[0]);
    push_random(1, depth[1]);
    check_status();
    run_frames(1, 1'b0);
    run_frames(3, 1'b0);

    // Reset in the middle of an all-ones left word.
    do_reset();
    tx_en = 1'b1;
    push_frame(0, 48'h0000_FFFF_1234);
    push_frame(1, 48'h123456_FFFFFF);
    run_frames(1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      if (j == 0) lrc = 1'b0;
      bclk = 1'b0;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    check("a_dac_midword", a_dac, 1'b1);
    check("b_dac_midword", b_dac, 1'b1);
    rst = 1'b1;
    bclk = 1'b0;
    @(negedge clk);
    check("a_dac_after_rst", a_dac, 1'b0);
    check("b_dac_after_rst", b_dac, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_status();
    push_random(0, 2);
    push_random(1, 2);
    run_frames(3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
